// File: rtl/ula_sequencial.sv
// ula_sequencial: handshaked ALU with one registered compute cycle; holds result and flags until the consumer accepts them
module ula_sequencial #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          EntValida,
    output logic          EntPronta,
    input  logic [2:0]    ULAControle,
    input  logic [N-1:0]  SrcA,
    input  logic [N-1:0]  SrcB,
    output logic          SaiValida,
    input  logic          SaiPronta,
    output logic [N-1:0]  ULAResultado,
    output logic          Zero,
    output logic          Overflow,
    output logic          Erro,
    output logic [CW-1:0] Contagem
);
    typedef enum logic [1:0] {OCIOSO, CALC, CHEIO} estado_t;
    estado_t estado, prox;
    logic [N-1:0] a, b, soma, res;
    logic [N:0] dif;
    logic [2:0] op;
    logic ovf, err;
    assign EntPronta = estado == OCIOSO;
    assign SaiValida = estado == CHEIO;
    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO: prox = EntValida ? CALC : OCIOSO;
            CALC:   prox = CHEIO;
            CHEIO:  prox = SaiPronta ? OCIOSO : CHEIO;
            default: prox = OCIOSO;
        endcase
    end
    // dif keeps one extra bit so SLT reads the true sign even when A-B overflows N bits
    always_comb begin
        soma = a + b;
        dif  = {a[N-1], a} - {b[N-1], b};
        res  = '0;
        ovf  = 1'b0;
        err  = 1'b0;
        case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: begin
                res = soma;
                ovf = (a[N-1] == b[N-1]) && (soma[N-1] != a[N-1]);
            end
            3'b011: res = ~(a | b);
            3'b101: res = a ^ b;
            3'b110: begin
                res = dif[N-1:0];
                ovf = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
            end
            3'b111: res = {{(N-1){1'b0}}, dif[N]};
            default: err = 1'b1;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            estado       <= OCIOSO;
            a            <= '0;
            b            <= '0;
            op           <= '0;
            ULAResultado <= '0;
            Zero         <= 1'b1;
            Overflow     <= 1'b0;
            Erro         <= 1'b0;
            Contagem     <= '0;
        end else begin
            estado <= prox;
            if (estado == OCIOSO && EntValida) begin
                a  <= SrcA;
                b  <= SrcB;
                op <= ULAControle;
            end
            if (estado == CALC) begin
                ULAResultado <= res;
                Zero         <= res == '0;
                Overflow     <= ovf;
                Erro         <= err;
            end
            if (estado == CHEIO && SaiPronta)
                Contagem <= Contagem + 1'b1;
        end
    end
endmodule

// File: tb/tb_ula_sequencial.sv
// tb_ula_sequencial: directed checks of ula_sequencial results, flags, handshake, reset and counter wrap
module tb_ula_sequencial;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        EntValida = 1'b0;
    logic        EntPronta;
    logic [2:0]  ULAControle = 3'b000;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        SaiValida;
    logic        SaiPronta = 1'b0;
    logic [31:0] ULAResultado;
    logic        Zero, Overflow, Erro;
    logic [15:0] Contagem;
    logic        ep4, sv4, z4, o4, e4;
    logic [31:0] r4;
    logic [3:0]  cont4;
    int errors = 0;
    int checks = 0;
    int cnt = 0;

    ula_sequencial #(.N(32), .CW(16)) dut (
        .clk(clk), .reset(reset), .EntValida(EntValida), .EntPronta(EntPronta),
        .ULAControle(ULAControle), .SrcA(SrcA), .SrcB(SrcB), .SaiValida(SaiValida),
        .SaiPronta(SaiPronta), .ULAResultado(ULAResultado), .Zero(Zero),
        .Overflow(Overflow), .Erro(Erro), .Contagem(Contagem)
    );

    // narrow-counter copy sharing the same stimulus, so the wrap is reachable in few cycles
    ula_sequencial #(.N(32), .CW(4)) dut4 (
        .clk(clk), .reset(reset), .EntValida(EntValida), .EntPronta(ep4),
        .ULAControle(ULAControle), .SrcA(SrcA), .SrcB(SrcB), .SaiValida(sv4),
        .SaiPronta(SaiPronta), .ULAResultado(r4), .Zero(z4),
        .Overflow(o4), .Erro(e4), .Contagem(cont4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_entpronta"}, 32'(EntPronta), 32'd1);
        chk({tag, "_saivalida"}, 32'(SaiValida), 32'd0);
        chk({tag, "_res"}, ULAResultado, 32'd0);
        chk({tag, "_zero"}, 32'(Zero), 32'd1);
        chk({tag, "_ovf"}, 32'(Overflow), 32'd0);
        chk({tag, "_erro"}, 32'(Erro), 32'd0);
        chk({tag, "_cont"}, 32'(Contagem), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r, input logic z,
                          input logic o, input logic e);
        ULAControle = op;
        SrcA = a;
        SrcB = b;
        EntValida = 1'b1;
        SaiPronta = 1'b1;
        step();
        EntValida = 1'b0;
        chk({tag, "_calc_entpronta"}, 32'(EntPronta), 32'd0);
        chk({tag, "_calc_saivalida"}, 32'(SaiValida), 32'd0);
        step();
        chk({tag, "_saivalida"}, 32'(SaiValida), 32'd1);
        chk({tag, "_res"}, ULAResultado, r);
        chk({tag, "_zero"}, 32'(Zero), 32'(z));
        chk({tag, "_ovf"}, 32'(Overflow), 32'(o));
        chk({tag, "_erro"}, 32'(Erro), 32'(e));
        step();
        cnt++;
        chk({tag, "_back_idle"}, 32'(EntPronta), 32'd1);
        chk({tag, "_cont"}, 32'(Contagem), 32'(cnt));
    endtask

    initial begin
        logic [31:0] held;
        step();
        step();
        chk_reset("reset");
        reset = 1'b0;
        step();
        chk("idle_entpronta", 32'(EntPronta), 32'd1);

        run_op("add", 3'b010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
        run_op("sub_ovf", 3'b110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("add_ovf", 3'b010, 32'h80000000, 32'h80000000, 32'd0, 1'b1, 1'b1, 1'b0);
        run_op("slt_neg", 3'b111, 32'h80000000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        run_op("slt_pos", 3'b111, 32'd1, 32'h80000000, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("slt_eq", 3'b111, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("slt_wrap", 3'b111, 32'h7FFFFFFF, 32'h80000000, 32'd0, 1'b1, 1'b0, 1'b0);
        run_op("and", 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
        run_op("or", 3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
        run_op("xor", 3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
        run_op("nor", 3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 1'b0);
        run_op("inval", 3'b100, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1'b1, 1'b0, 1'b1);
        run_op("sub_plain", 3'b110, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0);

        // backpressure: result must hold while SaiPronta is low
        SaiPronta = 1'b0;
        ULAControle = 3'b010;
        SrcA = 32'd100;
        SrcB = 32'd23;
        EntValida = 1'b1;
        step();
        EntValida = 1'b0;
        step();
        chk("bp_first_valid", 32'(SaiValida), 32'd1);
        chk("bp_first_res", ULAResultado, 32'd123);
        for (int i = 0; i < 5; i++) begin
            SrcA = 32'(i * 77 + 1);
            ULAControle = 3'(i);
            EntValida = ~EntValida;
            step();
            chk("bp_valid", 32'(SaiValida), 32'd1);
            chk("bp_entpronta", 32'(EntPronta), 32'd0);
            chk("bp_res", ULAResultado, 32'd123);
            chk("bp_zero", 32'(Zero), 32'd0);
            chk("bp_cont", 32'(Contagem), 32'(cnt));
        end
        EntValida = 1'b0;
        SaiPronta = 1'b1;
        step();
        cnt++;
        chk("bp_release_cont", 32'(Contagem), 32'(cnt));
        chk("bp_release_idle", 32'(EntPronta), 32'd1);
        step();
        chk("bp_single_incr", 32'(Contagem), 32'(cnt));

        // reset during CALC
        ULAControle = 3'b010;
        SrcA = 32'd1;
        SrcB = 32'd1;
        EntValida = 1'b1;
        step();
        EntValida = 1'b0;
        reset = 1'b1;
        step();
        chk_reset("rst_calc");
        reset = 1'b0;
        cnt = 0;
        step();
        step();
        chk("rst_calc_novalid", 32'(SaiValida), 32'd0);
        chk("rst_calc_cont", 32'(Contagem), 32'd0);

        // reset during CHEIO, with the consumer ready on the same edge
        ULAControle = 3'b000;
        SrcA = 32'hFFFFFFFF;
        SrcB = 32'h0000FFFF;
        EntValida = 1'b1;
        SaiPronta = 1'b1;
        step();
        EntValida = 1'b0;
        step();
        chk("rst_full_pre", ULAResultado, 32'h0000FFFF);
        reset = 1'b1;
        step();
        chk_reset("rst_full");
        reset = 1'b0;
        step();
        step();
        chk("rst_full_cont", 32'(Contagem), 32'd0);

        // counter wrap on the narrow instance
        for (int i = 0; i < 15; i++) begin
            SrcA = 32'(i);
            SrcB = 32'd1;
            run_op("wrap_fill", 3'b010, 32'(i), 32'd1, 32'(i + 1), 1'b0, 1'b0, 1'b0);
        end
        chk("wrap_full", 32'(cont4), 32'hF);
        run_op("wrap_last", 3'b010, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1'b0);
        chk("wrap_zero", 32'(cont4), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
